instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 127 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches one instruction at a time from instruction
// memory and presents it to decode. PC redirects (branch, jal, jalr) are taken
// when the presented instruction is consumed. A target with bit[1] set parks
// the unit in a sticky fault state until reset.
module instr_fetch_unit #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  // Redirect control from the control unit
  input  logic                     PCSrc,
  input  logic                     jalrmuxSel,
  input  logic [ADDRESS_WIDTH-1:0] PCTarget,
  input  logic [ADDRESS_WIDTH-1:0] ALUResult,
  input  logic                     stall,
  // Instruction memory
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  // Decode side
  output logic [31:0]              instr,
  output logic [6:0]               op,
  output logic [2:0]               funct3,
  output logic                     funct7,
  output logic                     instr_valid,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4,
  output logic                     fault
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StValid = 2'd2,
    StFault = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [31:0]              instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic [ADDRESS_WIDTH-1:0] redirect_target;
  logic [ADDRESS_WIDTH-1:0] next_pc;
  logic                     unused_bits;

  // Sequential address (wraps modulo 2^ADDRESS_WIDTH) and redirect target selection.
  always_comb begin
    pc_inc          = pc_q + ADDRESS_WIDTH'(4);
    redirect_target = jalrmuxSel ? {ALUResult[ADDRESS_WIDTH-1:1], 1'b0} : PCTarget;
    next_pc         = PCSrc ? redirect_target : pc_inc;
  end

  // Next-state logic: fetch handshake, consume and redirect, fault trap.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    unique case (state_q)
      StIdle: begin
        state_d    = StReq;
        fetch_pc_d = RESET_PC;
      end
      StReq: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          pc_d    = fetch_pc_q;
          state_d = StValid;
        end
      end
      StValid: begin
        if (!stall) begin
          // A misaligned target is trapped rather than fetched.
          if (next_pc[1]) begin
            state_d = StFault;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = StReq;
          end
        end
      end
      StFault: begin
        state_d = StFault;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

  // Outputs decode purely from state so reset clears them immediately.
  always_comb begin
    imem_req    = (state_q == StReq);
    instr_valid = (state_q == StValid);
    fault       = (state_q == StFault);
    imem_addr   = {fetch_pc_q[ADDRESS_WIDTH-1:2], 2'b00};
    instr       = instr_q;
    op          = instr_q[6:0];
    funct3      = instr_q[14:12];
    funct7      = instr_q[30];
    pc          = pc_q;
    pc_plus4    = pc_inc;
  end

  // Low address bits never reach memory; jalr drops bit 0 by definition.
  assign unused_bits = ^{ALUResult[0], fetch_pc_q[1:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, fetch handshake, stall hold,
// branch/jalr redirect, delayed ack, misaligned fault, reset mid-request, wrap.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        PCSrc;
  logic        jalrmuxSel;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;

  int n_pass  = 0;
  int n_total = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .PCSrc       (PCSrc),
    .jalrmuxSel  (jalrmuxSel),
    .PCTarget    (PCTarget),
    .ALUResult   (ALUResult),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .fault       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    rst        = 1'b1;
    PCSrc      = 1'b0;
    jalrmuxSel = 1'b0;
    PCTarget   = '0;
    ALUResult  = '0;
    stall      = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    tick();
    tick();

    // Reset values
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);

    // Release: one idle cycle, then first fetch at RESET_PC
    rst = 1'b0;
    check("idle_req", 32'(imem_req), 32'd0);
    tick();
    check("req0_req", 32'(imem_req), 32'd1);
    check("req0_addr", imem_addr, 32'h0);
    check("req0_valid", 32'(instr_valid), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0050_0093;
    tick();
    imem_ack = 1'b0;
    check("v0_valid", 32'(instr_valid), 32'd1);
    check("v0_op", 32'(op), 32'h13);
    check("v0_f3", 32'(funct3), 32'd0);
    check("v0_f7", 32'(funct7), 32'd0);
    check("v0_pc", pc, 32'h0);
    check("v0_pc4", pc_plus4, 32'h4);
    check("v0_req", 32'(imem_req), 32'd0);
    tick();
    check("req1_req", 32'(imem_req), 32'd1);
    check("req1_addr", imem_addr, 32'h4);
    check("req1_valid", 32'(instr_valid), 32'd0);

    // Stall hold; stray ack and redirect request are ignored while stalled
    imem_ack   = 1'b1;
    imem_rdata = 32'h00a0_0113;
    stall      = 1'b1;
    tick();
    imem_rdata = 32'hdead_beef;
    PCSrc      = 1'b1;
    PCTarget   = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_instr", instr, 32'h00a0_0113);
      check("stall_pc", pc, 32'h4);
      check("stall_req", 32'(imem_req), 32'd0);
    end
    imem_ack = 1'b0;
    PCSrc    = 1'b0;
    stall    = 1'b0;
    tick();
    check("seq_addr", imem_addr, 32'h8);

    // Branch/jal redirect
    imem_ack   = 1'b1;
    imem_rdata = 32'h0400_006f;
    tick();
    imem_ack = 1'b0;
    check("v2_pc", pc, 32'h8);
    PCSrc    = 1'b1;
    PCTarget = 32'h40;
    tick();
    check("br_addr", imem_addr, 32'h40);
    PCSrc      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    check("br_pc", pc, 32'h40);
    check("br_pc4", pc_plus4, 32'h44);

    // jalr redirect clears bit 0
    PCSrc      = 1'b1;
    jalrmuxSel = 1'b1;
    ALUResult  = 32'h81;
    tick();
    check("jalr_addr", imem_addr, 32'h80);
    PCSrc      = 1'b0;
    jalrmuxSel = 1'b0;
    imem_ack   = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("jalr_pc", pc, 32'h80);
    tick();

    // Delayed ack: request held stable
    for (int i = 0; i < 4; i++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, 32'h84);
      check("wait_valid", 32'(instr_valid), 32'd0);
      tick();
    end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("late_pc", pc, 32'h84);
    check("late_valid", 32'(instr_valid), 32'd1);

    // Misaligned target traps
    PCSrc    = 1'b1;
    PCTarget = 32'h42;
    tick();
    PCSrc = 1'b0;
    check("flt_fault", 32'(fault), 32'd1);
    check("flt_req", 32'(imem_req), 32'd0);
    check("flt_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      imem_ack = i[0];
      tick();
      check("flt_hold_req", 32'(imem_req), 32'd0);
      check("flt_hold_fault", 32'(fault), 32'd1);
    end
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    check("flt_clear", 32'(fault), 32'd0);
    tick();
    rst = 1'b0;
    check("flt_idle_req", 32'(imem_req), 32'd0);
    tick();
    check("flt_re_req", 32'(imem_req), 32'd1);
    check("flt_re_addr", imem_addr, 32'h0);

    // Reset mid-request, ack during reset is discarded
    rst = 1'b1;
    #1;
    check("mid_rst_req", 32'(imem_req), 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    imem_ack = 1'b0;
    rst      = 1'b0;
    tick();
    check("post_rst_req", 32'(imem_req), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);

    // Address wrap at top of memory
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    tick();
    imem_ack = 1'b0;
    PCSrc    = 1'b1;
    PCTarget = 32'hffff_fffc;
    tick();
    PCSrc = 1'b0;
    check("top_addr", imem_addr, 32'hffff_fffc);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("top_pc", pc, 32'hffff_fffc);
    check("top_pc4", pc_plus4, 32'h0);
    tick();
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", 32'(imem_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
